reg_serial_tx: RTL and testbench

//   Serial transmitter for the 4-bit switch register: snapshots the register's parallel
//   out[3:0] on a send request and shifts it out on one wire as an async-style frame.

---
 rtl/reg_serial_tx_if.sv | 27 ++
 rtl/reg_serial_tx.sv | 119 +++++++++++
 tb/tb_reg_serial_tx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_serial_tx_if.sv
// Bundles the parallel-load request side and the serial/status side of the
// switch-register transmitter.
//   data_in : parallel word from the switch register
//   send    : frame request (level-sampled by the transmitter while idle)
//   tx      : serial line, idles high
//   busy    : high while a frame is on the line
//   done    : one-cycle pulse when a frame completes
// master = the block issuing requests, slave = the transmitter.
interface reg_serial_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] data_in;
   logic             send;
   logic             tx;
   logic             busy;
   logic             done;

   modport master (
      output data_in, send,
      input  tx, busy, done
   );

   modport slave (
      input  data_in, send,
      output tx, busy, done
   );
endinterface

// File: rtl/reg_serial_tx.sv
// Serial transmitter for the 4-bit switch register. On an accepted send it
// snapshots data_in and shifts out one frame on tx:
//   start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT cycles. All outputs are registered.
// Ports:
//   clock : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : reg_serial_tx_if.slave (data_in, send in; tx, busy, done out)
module reg_serial_tx #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic           clock,
   input  logic           reset,
   reg_serial_tx_if.slave bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [WIDTH-1:0]  shift_reg;
   logic [WIDTH-1:0]  shift_next;
   logic              tx_r;
   logic              busy_r;
   logic              done_r;
   logic              bit_end;

   assign shift_next = shift_reg >> 1;
   assign bit_end    = (baud_cnt == BAUD_MAX);

   // tx is loaded with the value of the bit being entered on the same edge
   // that changes state, so the line is registered yet has no extra lag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx_r      <= 1'b1;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               tx_r     <= 1'b1;
               busy_r   <= 1'b0;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (bus.send) begin
                  shift_reg <= bus.data_in;
                  state     <= START;
                  tx_r      <= 1'b0;
                  busy_r    <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= DATA;
                  tx_r     <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == BIT_MAX) begin
                     state <= STOP;
                     tx_r  <= 1'b1;
                  end else begin
                     bit_cnt   <= bit_cnt + 1'b1;
                     shift_reg <= shift_next;
                     tx_r      <= shift_next[0];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  tx_r     <= 1'b1;
                  busy_r   <= 1'b0;
                  done_r   <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx_r     <= 1'b1;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx   = tx_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

endmodule

// File: tb/tb_reg_serial_tx.sv
// Scoreboard bench for reg_serial_tx: one instance with CLKS_PER_BIT=4 and
// one with CLKS_PER_BIT=1. Stimulus pushes the expected tx bit stream of
// every frame it expects to be accepted; per-instance monitors pop and
// compare on each busy cycle and check done pulses and frame length.
module tb_reg_serial_tx;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   reg_serial_tx_if #(.WIDTH(4)) b4 ();
   reg_serial_tx_if #(.WIDTH(4)) b1 ();

   reg_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (b4.slave)
   );

   reg_serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (b1.slave)
   );

   int n_pass  = 0;
   int n_total = 0;

   bit q4[$];
   bit q1[$];
   int done_exp4 = 0;
   int done_exp1 = 0;
   int cnt4 = 0;
   int cnt1 = 0;
   int done_seen4 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_frame(input int which, input logic [3:0] d, input int c);
      for (int k = 0; k < c; k++) begin
         if (which == 4) q4.push_back(1'b0); else q1.push_back(1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < c; k++) begin
            if (which == 4) q4.push_back(d[i]); else q1.push_back(d[i]);
         end
      end
      for (int k = 0; k < c; k++) begin
         if (which == 4) q4.push_back(1'b1); else q1.push_back(1'b1);
      end
      if (which == 4) done_exp4++; else done_exp1++;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_done(input int which, input int maxc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < maxc && !seen; i++) begin
         @(posedge clock);
         #1;
         if ((which == 4) ? b4.done : b1.done) seen = 1'b1;
      end
      if (!seen) begin
         n_total++;
         $display("FAIL wait_done%0d: no done within %0d cycles", which, maxc);
      end
   endtask

   // Monitor for the CLKS_PER_BIT=4 instance.
   always @(negedge clock) begin
      if (!reset) begin
         if (b4.busy) begin
            cnt4++;
            if (q4.size() == 0) chk("busy4_without_frame", b4.busy, 0);
            else chk("tx4_bit", b4.tx, q4.pop_front());
         end else begin
            chk("tx4_idle_high", b4.tx, 1);
            if (b4.done) begin
               done_seen4++;
               chk("done4_expected", b4.done, (done_exp4 > 0));
               if (done_exp4 > 0) done_exp4--;
               chk("frame4_len", cnt4, 24);
            end
            cnt4 = 0;
         end
      end
   end

   // Monitor for the CLKS_PER_BIT=1 instance.
   always @(negedge clock) begin
      if (!reset) begin
         if (b1.busy) begin
            cnt1++;
            if (q1.size() == 0) chk("busy1_without_frame", b1.busy, 0);
            else chk("tx1_bit", b1.tx, q1.pop_front());
         end else begin
            chk("tx1_idle_high", b1.tx, 1);
            if (b1.done) begin
               chk("done1_expected", b1.done, (done_exp1 > 0));
               if (done_exp1 > 0) done_exp1--;
               chk("frame1_len", cnt1, 6);
            end
            cnt1 = 0;
         end
      end
   end

   initial begin
      b4.data_in = '0;
      b4.send    = 1'b0;
      b1.data_in = '0;
      b1.send    = 1'b0;
      step(3);
      reset = 1'b0;

      // reset state
      chk("rst_tx4", b4.tx, 1);
      chk("rst_busy4", b4.busy, 0);
      chk("rst_done4", b4.done, 0);
      chk("rst_tx1", b1.tx, 1);
      chk("rst_busy1", b1.busy, 0);
      step(2);

      // 1) 4'b1011, single-cycle send
      b4.data_in = 4'b1011;
      b4.send    = 1'b1;
      push_frame(4, 4'b1011, 4);
      step(1);
      b4.send = 1'b0;
      chk("accept_busy", b4.busy, 1);
      chk("start_tx", b4.tx, 0);
      wait_done(4, 40);
      step(3);

      // 2) send pulses at frame cycles 5 and 12 are ignored
      done_seen4 = 0;
      b4.data_in = 4'h6;
      b4.send    = 1'b1;
      push_frame(4, 4'h6, 4);
      step(1);
      b4.send = 1'b0;
      step(4);
      b4.send = 1'b1;
      step(1);
      b4.send = 1'b0;
      step(6);
      b4.send = 1'b1;
      step(1);
      b4.send = 1'b0;
      wait_done(4, 40);
      step(30);
      chk("ignored_send_one_done", done_seen4, 1);

      // 3) send held high: back-to-back frames
      b4.data_in = 4'h3;
      b4.send    = 1'b1;
      push_frame(4, 4'h3, 4);
      push_frame(4, 4'hC, 4);
      step(1);
      b4.data_in = 4'hC;
      wait_done(4, 40);
      step(1);
      b4.send = 1'b0;
      chk("b2b_busy", b4.busy, 1);
      chk("b2b_tx_start", b4.tx, 0);
      wait_done(4, 40);
      step(3);

      // 4) reset at cycle 10 of a frame aborts it
      b4.data_in = 4'hA;
      b4.send    = 1'b1;
      push_frame(4, 4'hA, 4);
      step(1);
      b4.send = 1'b0;
      step(9);
      reset = 1'b1;
      step(1);
      q4.delete();
      done_exp4 = 0;
      chk("abort_tx", b4.tx, 1);
      chk("abort_busy", b4.busy, 0);
      chk("abort_done", b4.done, 0);
      reset = 1'b0;
      step(30);

      // 5) CLKS_PER_BIT=1, 4'h5
      b1.data_in = 4'h5;
      b1.send    = 1'b1;
      push_frame(1, 4'h5, 1);
      step(1);
      b1.send = 1'b0;
      wait_done(1, 20);
      step(3);

      // 6) data_in changes right after accept
      b4.data_in = 4'hF;
      b4.send    = 1'b1;
      push_frame(4, 4'hF, 4);
      step(1);
      b4.send    = 1'b0;
      b4.data_in = 4'h0;
      wait_done(4, 40);
      step(3);

      chk("q4_drained", q4.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("done4_all_seen", done_exp4, 0);
      chk("done1_all_seen", done_exp1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

endmodule
